// File: rtl/super_i3_ctrl_pkg.sv
// Shared constants and FSM state encoding for the super_i3 frame controller.
package super_i3_ctrl_pkg;

  localparam int cWORD_W      = 128;
  localparam int cDATA_WORDS  = 239;
  localparam int cCODE_WORDS  = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    FLUSH  = 2'd3
  } state_t;

endpackage

// File: rtl/super_i3_frame_ctrl.sv
// Frames 239 source words into 255-word code frames (parity slots zeroed for the
// encoder) and emits whole zero frames on a flush request.
module super_i3_frame_ctrl
  import super_i3_ctrl_pkg::*;
#(
  parameter int pFLUSH_FRAMES = 21,
  parameter int pCNT_W        = 16
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ival,
  input  logic [cWORD_W-1:0] idat,
  output logic               ordy,
  input  logic               iflush,
  output logic               oval,
  output logic               osop,
  output logic [cWORD_W-1:0] odat,
  output logic               obusy,
  output logic               oflush_done,
  output logic [pCNT_W-1:0]  ofrm_cnt
);

  localparam int              cFCNT_W     = $clog2(pFLUSH_FRAMES + 1);
  localparam logic [7:0]      cLAST_DATA  = 8'(cDATA_WORDS - 1);
  localparam logic [7:0]      cLAST_CODE  = 8'(cCODE_WORDS - 1);
  localparam logic [cFCNT_W-1:0] cLAST_FRAME = cFCNT_W'(pFLUSH_FRAMES - 1);

  state_t               r_state;
  logic [7:0]           r_widx;
  logic                 r_flush_pend;
  logic [cFCNT_W-1:0]   r_fcnt;
  logic                 r_done_arm;
  logic                 r_oval;
  logic                 r_osop;
  logic [cWORD_W-1:0]   r_odat;
  logic                 r_oflush_done;
  logic [pCNT_W-1:0]    r_frm_cnt;

  logic w_xfer;
  logic w_flush_req;
  logic w_code_end;

  assign ordy        = !ireset && ((r_state == IDLE) || (r_state == DATA));
  assign w_xfer      = ival & ordy & iclkena;
  // A flush request arriving this very cycle counts as pending for the decision.
  assign w_flush_req = r_flush_pend | (iflush & (r_state != FLUSH));
  assign w_code_end  = (r_widx == cLAST_CODE);

  assign oval        = r_oval;
  assign osop        = r_osop;
  assign odat        = r_odat;
  assign obusy       = (r_state != IDLE);
  assign oflush_done = r_oflush_done;
  assign ofrm_cnt    = r_frm_cnt;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_state       <= IDLE;
      r_widx        <= '0;
      r_flush_pend  <= 1'b0;
      r_fcnt        <= '0;
      r_done_arm    <= 1'b0;
      r_oval        <= 1'b0;
      r_osop        <= 1'b0;
      r_odat        <= '0;
      r_oflush_done <= 1'b0;
      r_frm_cnt     <= '0;
    end else if (iclkena) begin
      r_oval        <= 1'b0;
      r_osop        <= 1'b0;
      r_odat        <= '0;
      r_oflush_done <= r_done_arm;
      r_done_arm    <= 1'b0;
      if (iflush && (r_state != FLUSH)) begin
        r_flush_pend <= 1'b1;
      end

      case (r_state)
        // Word index 0 in DATA behaves exactly like IDLE, so both share this arm.
        IDLE, DATA: begin
          if (w_xfer) begin
            r_oval <= 1'b1;
            r_osop <= (r_widx == 8'd0);
            r_odat <= idat;
            r_widx <= r_widx + 8'd1;
            r_state <= (r_widx == cLAST_DATA) ? PARITY : DATA;
          end else if ((r_widx == 8'd0) && w_flush_req) begin
            r_state <= FLUSH;
            r_fcnt  <= '0;
          end
        end

        PARITY: begin
          r_oval <= 1'b1;
          if (w_code_end) begin
            r_widx    <= '0;
            r_fcnt    <= '0;
            r_frm_cnt <= r_frm_cnt + pCNT_W'(1);
            r_state   <= w_flush_req ? FLUSH : DATA;
          end else begin
            r_widx <= r_widx + 8'd1;
          end
        end

        FLUSH: begin
          r_oval <= 1'b1;
          r_osop <= (r_widx == 8'd0);
          if (w_code_end) begin
            r_widx <= '0;
            if (r_fcnt == cLAST_FRAME) begin
              r_fcnt       <= '0;
              r_state      <= IDLE;
              r_flush_pend <= 1'b0;
              r_done_arm   <= 1'b1;
            end else begin
              r_fcnt <= r_fcnt + cFCNT_W'(1);
            end
          end else begin
            r_widx <= r_widx + 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_super_i3_frame_ctrl.sv
// Scoreboard bench for super_i3_frame_ctrl: stimulus pushes expected output words,
// a monitor pops and compares them whenever the controller presents a word.
module tb_super_i3_frame_ctrl;
  import super_i3_ctrl_pkg::*;

  localparam int FLUSH_N = 2;
  localparam int CNT_W   = 16;

  logic               iclk = 1'b0;
  logic               ireset;
  logic               iclkena;
  logic               ival;
  logic [cWORD_W-1:0] idat;
  logic               ordy;
  logic               iflush;
  logic               oval;
  logic               osop;
  logic [cWORD_W-1:0] odat;
  logic               obusy;
  logic               oflush_done;
  logic [CNT_W-1:0]   ofrm_cnt;

  typedef struct {
    logic               sop;
    logic [cWORD_W-1:0] dat;
    bit                 follow;
  } exp_t;

  exp_t expQ[$];
  int   checks    = 0;
  int   failures  = 0;
  int   doneCount = 0;
  bit   pendFlush = 0;
  bit   monEn;
  bit   lastVal   = 0;
  bit   prevDone  = 0;

  super_i3_frame_ctrl #(.pFLUSH_FRAMES(FLUSH_N), .pCNT_W(CNT_W)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .idat(idat),
    .ordy(ordy), .iflush(iflush), .oval(oval), .osop(osop), .odat(odat),
    .obusy(obusy), .oflush_done(oflush_done), .ofrm_cnt(ofrm_cnt)
  );

  always #5 iclk = ~iclk;

  function automatic logic [cWORD_W-1:0] mkWord(input int f, input int i);
    return {32'(f), 32'(i), 32'hC0DE_0000 | 32'(i), ~32'(i)};
  endfunction

  task automatic checkOutput(input string name, input logic [cWORD_W-1:0] act,
                             input logic [cWORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushWord(input logic sop, input logic [cWORD_W-1:0] dat, input bit follow);
    exp_t e;
    e.sop = sop; e.dat = dat; e.follow = follow;
    expQ.push_back(e);
  endtask

  task automatic pushFlushWords();
    for (int f = 0; f < FLUSH_N; f++)
      for (int w = 0; w < cCODE_WORDS; w++)
        pushWord(w == 0, '0, !(f == 0 && w == 0));
  endtask

  task automatic pushParityWords();
    for (int p = 0; p < cCODE_WORDS - cDATA_WORDS; p++) pushWord(1'b0, '0, 1'b1);
    if (pendFlush) begin
      pushFlushWords();
      pendFlush = 0;
    end
  endtask

  // Sends stopAt words of a frame; optional gaps, flush pulse at word flushAt,
  // and a 5-cycle clock-enable freeze in the middle of the parity burst.
  task automatic applyStimulus(input int frameId, input bit gaps, input int flushAt,
                               input int stopAt, input bit freeze);
    int i = 0;
    int guard = 0;
    while (i < stopAt) begin
      @(negedge iclk);
      ival = 1'b0; iflush = 1'b0;
      guard++;
      if (guard > 2000) begin
        checks++; failures++;
        $display("[TB] FAIL frame_timeout: got word %0d expected %0d", i, stopAt);
        break;
      end
      if (ordy && !(gaps && (guard % 2 == 1))) begin
        ival = 1'b1;
        idat = mkWord(frameId, i);
        pushWord(i == 0, idat, 1'b0);
        if (i == flushAt) begin
          iflush = 1'b1;
          pendFlush = 1;
        end
        if (i == cDATA_WORDS - 1) pushParityWords();
        i++;
      end
    end
    @(negedge iclk);
    ival = 1'b0; iflush = 1'b0;
    if (stopAt == cDATA_WORDS) checkOutput("ordy_in_parity", ordy, 0);
    if (freeze) begin
      repeat (3) @(negedge iclk);
      iclkena = 1'b0;
      repeat (5) begin
        @(negedge iclk);
        checkOutput("freeze_oval", oval, 1);
        checkOutput("freeze_odat", odat, 0);
        checkOutput("freeze_ordy", ordy, 0);
      end
      iclkena = 1'b1;
    end
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (expQ.size() != 0 && n < limit) begin
      @(negedge iclk);
      n++;
    end
    checkOutput("drain_remaining", expQ.size(), 0);
    expQ.delete();
    repeat (3) @(negedge iclk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge iclk);
      monEn = iclkena && !ireset;
      #1;
      if (ireset) begin
        lastVal = 0; prevDone = 0;
      end else if (monEn) begin
        if (oflush_done) begin
          doneCount++;
          checkOutput("done_after_last_word", expQ.size(), 0);
          checkOutput("done_single_cycle", prevDone, 0);
        end
        if (oval) begin
          if (expQ.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_word: got odat=%0h expected no word", odat);
          end else begin
            e = expQ.pop_front();
            if (e.follow) checkOutput("contiguous", lastVal, 1);
            checkOutput("osop", osop, e.sop);
            checkOutput("odat", odat, e.dat);
          end
        end
        lastVal  = oval;
        prevDone = oflush_done;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; iflush = 1'b0; idat = '0;
    repeat (3) @(negedge iclk);
    checkOutput("rst_oval", oval, 0);
    checkOutput("rst_osop", osop, 0);
    checkOutput("rst_odat", odat, 0);
    checkOutput("rst_done", oflush_done, 0);
    checkOutput("rst_frm_cnt", ofrm_cnt, 0);
    checkOutput("rst_ordy", ordy, 0);
    checkOutput("rst_obusy", obusy, 0);
    ireset = 1'b0;
    @(negedge iclk);
    checkOutput("idle_ordy", ordy, 1);

    // Flush straight from IDLE.
    iflush = 1'b1;
    pushFlushWords();
    @(negedge iclk);
    iflush = 1'b0;
    waitDrain(FLUSH_N * cCODE_WORDS + 50);
    checkOutput("idle_flush_done_cnt", doneCount, 1);
    checkOutput("idle_flush_obusy", obusy, 0);
    checkOutput("idle_flush_frm_cnt", ofrm_cnt, 0);

    applyStimulus(1, 0, -1, cDATA_WORDS, 0);
    waitDrain(100);
    checkOutput("frm_cnt_1", ofrm_cnt, 1);
    checkOutput("obusy_wait_sop", obusy, 1);

    applyStimulus(2, 1, -1, cDATA_WORDS, 0);
    waitDrain(100);
    checkOutput("frm_cnt_gaps", ofrm_cnt, 2);

    applyStimulus(3, 0, -1, cDATA_WORDS, 1);
    waitDrain(100);
    checkOutput("frm_cnt_freeze", ofrm_cnt, 3);

    // Flush at data word 100, plus an ignored second request mid-flush.
    applyStimulus(4, 0, 100, cDATA_WORDS, 0);
    repeat (300) @(negedge iclk);
    checkOutput("busy_in_flush", obusy, 1);
    iflush = 1'b1;
    @(negedge iclk);
    iflush = 1'b0;
    waitDrain(FLUSH_N * cCODE_WORDS + 100);
    checkOutput("mid_flush_done_cnt", doneCount, 2);
    checkOutput("mid_flush_frm_cnt", ofrm_cnt, 4);
    repeat (50) @(negedge iclk);
    checkOutput("second_flush_ignored", doneCount, 2);
    checkOutput("after_flush_obusy", obusy, 0);

    // Flush coincident with the sop transfer.
    applyStimulus(5, 0, 0, cDATA_WORDS, 0);
    waitDrain(FLUSH_N * cCODE_WORDS + 100);
    checkOutput("sop_flush_done_cnt", doneCount, 3);
    checkOutput("sop_flush_frm_cnt", ofrm_cnt, 5);

    // Asynchronous reset at data word 50.
    applyStimulus(6, 0, -1, 50, 0);
    #2 ireset = 1'b1;
    #1;
    checkOutput("async_rst_oval", oval, 0);
    checkOutput("async_rst_odat", odat, 0);
    checkOutput("async_rst_frm_cnt", ofrm_cnt, 0);
    checkOutput("async_rst_ordy", ordy, 0);
    checkOutput("async_rst_obusy", obusy, 0);
    checkOutput("async_rst_pending", expQ.size(), 0);
    @(negedge iclk);
    ireset = 1'b0;
    repeat (20) @(negedge iclk);
    applyStimulus(7, 0, -1, cDATA_WORDS, 0);
    waitDrain(100);
    checkOutput("post_rst_frm_cnt", ofrm_cnt, 1);
    checkOutput("post_rst_done_cnt", doneCount, 3);

    repeat (20) @(negedge iclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/super_i3_frame_ctrl.md
SUPER_I3_FRAME_CTRL -- requirements
Module: super_i3_frame_ctrl

Interface
REQ-001 SHALL have parameter pFLUSH_FRAMES, default 21, giving the number of zero frames emitted per flush (pITER*7 for pITER=3).
REQ-002 SHALL have parameter pCNT_W, default 16, giving the width of the completed-frame counter.
REQ-003 iclk  in  1  single clock; all logic on posedge.
REQ-004 ireset  in  1  reset, asynchronous, active-high.
REQ-005 iclkena  in  1  clock enable; when low, all state and outputs hold.
REQ-006 ival  in  1  source data word valid.
REQ-007 idat  in  128  source data word; bit j is payload bit 128*i+j of word i.
REQ-008 ordy  out  1  controller accepts idat this cycle (combinational from state).
REQ-009 iflush  in  1  flush request pulse.
REQ-010 oval  out  1  word valid to super_i3_enc.
REQ-011 osop  out  1  first word of a 255-word code frame.
REQ-012 odat  out  128  word to encoder.
REQ-013 obusy  out  1  state is not IDLE.
REQ-014 oflush_done  out  1  single-cycle pulse after the last flush word.
REQ-015 ofrm_cnt  out  pCNT_W  completed data frames, wraps modulo 2^pCNT_W.

Function
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY and FLUSH.
REQ-017 A transfer is ival & ordy & iclkena; ordy SHALL be 1 in IDLE and DATA only.
REQ-018 Each transfer SHALL drive odat=idat and oval=1 on the next edge (latency 1); osop=1 only when word index is 0.
REQ-019 IDLE: a transfer SHALL set word index to 1 and go to DATA; otherwise, with a flush pending, go to FLUSH.
REQ-020 DATA: gaps (ival=0) are allowed and SHALL produce oval=0; the transfer of word 238 SHALL go to PARITY.
REQ-021 PARITY: SHALL emit 16 contiguous words, oval=1, odat=0, osop=0 (word indices 239..254).
REQ-022 After the last PARITY word, ofrm_cnt SHALL increment; next state is FLUSH if a flush is pending, else DATA with word index 0, which then accepts the next frame's sop word.
REQ-023 DATA at word index 0 with no transfer for the whole wait SHALL be equivalent to IDLE for flush handling.
REQ-024 iflush in any state other than FLUSH SHALL set flush_pending; iflush in FLUSH SHALL be ignored.
REQ-025 FLUSH: SHALL emit pFLUSH_FRAMES*255 contiguous words, oval=1, odat=0, osop=1 at each frame's word 0; ofrm_cnt SHALL not change.
REQ-026 After the last FLUSH word: oflush_done=1 for one cycle, flush_pending cleared, state IDLE.
REQ-027 iflush coincident with a sop transfer SHALL let the frame complete before FLUSH starts.
REQ-028 SHALL use an 8-bit word index (0..254) and a flush frame counter of width $clog2(pFLUSH_FRAMES+1).

Reset
REQ-029 ireset SHALL force state IDLE, word index 0, flush_pending 0, and oval, osop, odat, oflush_done and ofrm_cnt to 0 immediately, regardless of iclkena.
REQ-030 ordy SHALL be 0 while ireset=1.
REQ-031 Reset mid-frame or mid-flush SHALL discard the partial frame with no trailing parity or zero words.

Structure
REQ-032 Constants cWORD_W=128, cDATA_WORDS=239, cCODE_WORDS=255 and the FSM state enum SHALL live in the shared package super_i3_ctrl_pkg.
REQ-033 SHALL be a single module with no sub-modules; the encoder is instantiated by the parent.

Verification
REQ-034 239 words with continuous ival -> 255 oval words, osop on word 0, words 239..254 equal 0, ordy=0 during PARITY, ofrm_cnt=1.
REQ-035 Same stimulus with ival=0 every other cycle -> data words in order, no osop duplicated, 16 parity words contiguous.
REQ-036 iflush in IDLE, pFLUSH_FRAMES=2 -> 510 zero words, osop at words 0 and 255, oflush_done one cycle later, obusy back to 0.
REQ-037 iflush at data word 100 -> frame completes (255 words), then 21*255 zero words, then oflush_done; second iflush during FLUSH has no effect.
REQ-038 ireset asserted at data word 50 -> all outputs 0 asynchronously; after release, a new 239-word frame starts with osop and ofrm_cnt restarts at 0.
REQ-039 iclkena=0 for 5 cycles mid-PARITY -> outputs frozen; parity count resumes, still exactly 16 words.
